sram_responder: RTL and testbench

//  Memory-side responder for the SLC-3 core's memory bus. It answers the core's ADDR/OE/WE strobes

---
 rtl/sram_responder_if.sv | 27 ++
 rtl/sram_responder.sv | 116 +++++++++++
 tb/tb_sram_responder.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sram_responder_if.sv
// Bus bundle between the SLC-3 core (master) and the memory responder (slave):
// CPU strobes, read return path and the program preload port.
interface sram_responder_if #(
   parameter int DATA_W = 16
);
   logic [15:0]       ADDR;
   logic              OE;
   logic              WE;
   logic [DATA_W-1:0] Data_to_SRAM;
   logic [DATA_W-1:0] Data_from_SRAM;
   logic              Mem_Ready;
   logic              Load_Valid;
   logic [15:0]       Load_Addr;
   logic [DATA_W-1:0] Load_Data;
   logic              Load_Ready;
   logic              Init_Done;

   modport master (
      output ADDR, OE, WE, Data_to_SRAM, Load_Valid, Load_Addr, Load_Data,
      input  Data_from_SRAM, Mem_Ready, Load_Ready, Init_Done
   );

   modport slave (
      input  ADDR, OE, WE, Data_to_SRAM, Load_Valid, Load_Addr, Load_Data,
      output Data_from_SRAM, Mem_Ready, Load_Ready, Init_Done
   );
endinterface

// File: rtl/sram_responder.sv
// Word-addressed on-chip RAM answering the SLC-3 memory bus with a fixed read latency,
// plus a preload port that only gets the array when the CPU is idle.
module sram_responder #(
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 16,
   parameter int READ_LAT = 2
) (
   input logic              Clk,
   input logic              Reset,
   sram_responder_if.slave  bus
);
   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {CLEAR, SERVE} state_t;

   state_t              state;
   state_t              state_next;
   logic [ADDR_W-1:0]   clr_cnt;
   logic [DATA_W-1:0]   mem [DEPTH];

   logic                cpu_in_range;
   logic                load_in_range;
   logic                read_issue;
   logic [DATA_W-1:0]   read_word;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_waddr;
   logic [DATA_W-1:0]   mem_wdata;

   logic [READ_LAT-1:0] pipe_valid;
   logic [DATA_W-1:0]   pipe_data  [READ_LAT];
   logic [READ_LAT-1:0] stage_valid;
   logic [DATA_W-1:0]   stage_data [READ_LAT];

   assign cpu_in_range  = (bus.ADDR >> ADDR_W) == 16'd0;
   assign load_in_range = (bus.Load_Addr >> ADDR_W) == 16'd0;
   assign read_word     = cpu_in_range ? mem[bus.ADDR[ADDR_W-1:0]] : '0;

   assign bus.Init_Done  = (state == SERVE);
   assign bus.Load_Ready = bus.Init_Done & ~bus.OE & ~bus.WE;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state   <= CLEAR;
         clr_cnt <= '0;
      end else begin
         state <= state_next;
         if (state == CLEAR)
            clr_cnt <= clr_cnt + 1'b1;
      end
   end

   // One write port: the clear sweep, else the CPU, else the loader (only when the CPU is idle).
   always_comb begin
      state_next = state;
      mem_we     = 1'b0;
      mem_waddr  = clr_cnt;
      mem_wdata  = '0;
      read_issue = 1'b0;
      case (state)
         CLEAR: begin
            mem_we = 1'b1;
            if (clr_cnt == '1)
               state_next = SERVE;
         end
         SERVE: begin
            if (!Reset) begin
               if (bus.WE) begin
                  mem_we    = cpu_in_range;
                  mem_waddr = bus.ADDR[ADDR_W-1:0];
                  mem_wdata = bus.Data_to_SRAM;
               end else if (bus.OE) begin
                  read_issue = 1'b1;
               end else if (bus.Load_Valid && load_in_range) begin
                  mem_we    = 1'b1;
                  mem_waddr = bus.Load_Addr[ADDR_W-1:0];
                  mem_wdata = bus.Load_Data;
               end
            end
         end
         default: state_next = CLEAR;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (mem_we)
         mem[mem_waddr] <= mem_wdata;
   end

   always_comb begin
      stage_valid    = '0;
      stage_valid[0] = read_issue;
      stage_data[0]  = read_word;
      for (int i = 1; i < READ_LAT; i++) begin
         stage_valid[i] = pipe_valid[i-1];
         stage_data[i]  = pipe_data[i-1];
      end
   end

   // The last stage doubles as the output register, so it only loads on a valid result.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         pipe_valid <= '0;
         for (int i = 0; i < READ_LAT; i++)
            pipe_data[i] <= '0;
      end else begin
         pipe_valid <= stage_valid;
         for (int i = 0; i < READ_LAT; i++) begin
            if (stage_valid[i] || i != READ_LAT - 1)
               pipe_data[i] <= stage_data[i];
         end
      end
   end

   assign bus.Mem_Ready      = pipe_valid[READ_LAT-1];
   assign bus.Data_from_SRAM = pipe_data[READ_LAT-1];
endmodule

// File: tb/tb_sram_responder.sv
// Drives directed and random bus traffic into sram_responder and compares every cycle
// against a plain array-and-queue model of the memory and its read latency.
module tb_sram_responder;
   localparam int ADDR_W   = 10;
   localparam int DATA_W   = 16;
   localparam int READ_LAT = 2;
   localparam int DEPTH    = 1 << ADDR_W;

   typedef struct {
      int          due;
      logic [15:0] data;
   } exp_t;

   logic Clk = 1'b0;
   logic Reset;

   sram_responder_if #(.DATA_W(DATA_W)) bus ();

   sram_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   logic [15:0] model_mem [DEPTH];
   exp_t        pending [$];
   int          clear_left;
   logic [15:0] last_data;
   int          cyc;
   int          n_compared;
   int          n_mismatched;

   task automatic checkEq(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_compared++;
      assert (obs === expv) else begin
         n_mismatched++;
         $error("[TB] FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, expv);
      end
   endtask

   function automatic bit inRange(input logic [15:0] a);
      return a < 16'(DEPTH);
   endfunction

   task automatic modelReset();
      for (int i = 0; i < DEPTH; i++)
         model_mem[i] = 16'h0000;
      pending.delete();
      clear_left = DEPTH;
      last_data  = 16'h0000;
   endtask

   // Compare the registered outputs just after an edge with what the model expects.
   task automatic checkOutput();
      logic exp_ready;
      exp_ready = 1'b0;
      if (pending.size() > 0 && pending[0].due == cyc) begin
         exp_ready = 1'b1;
         last_data = pending[0].data;
         void'(pending.pop_front());
      end
      checkEq("mem_ready", {15'd0, bus.Mem_Ready}, {15'd0, exp_ready});
      checkEq("read_data", bus.Data_from_SRAM, last_data);
      checkEq("init_done", {15'd0, bus.Init_Done}, {15'd0, clear_left == 0});
   endtask

   // One bus cycle: drive inputs, check the combinational ready, take the edge, update model, check.
   task automatic applyStimulus(input logic rst, input logic oe, input logic we,
                                input logic [15:0] addr, input logic [15:0] din,
                                input logic lv, input logic [15:0] laddr, input logic [15:0] ldata);
      Reset            = rst;
      bus.OE           = oe;
      bus.WE           = we;
      bus.ADDR         = addr;
      bus.Data_to_SRAM = din;
      bus.Load_Valid   = lv;
      bus.Load_Addr    = laddr;
      bus.Load_Data    = ldata;
      #1;
      checkEq("load_ready", {15'd0, bus.Load_Ready}, {15'd0, (clear_left == 0) && !oe && !we});
      @(posedge Clk);
      cyc++;
      if (rst) begin
         modelReset();
      end else if (clear_left > 0) begin
         clear_left--;
      end else begin
         if (we) begin
            if (inRange(addr)) model_mem[addr] = din;
         end else if (oe) begin
            pending.push_back('{due: cyc + READ_LAT - 1,
                                data: inRange(addr) ? model_mem[addr] : 16'h0000});
         end else if (lv && inRange(laddr)) begin
            model_mem[laddr] = ldata;
         end
      end
      #1;
      checkOutput();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
   endtask

   task automatic cpuWrite(input logic [15:0] a, input logic [15:0] d);
      applyStimulus(1'b0, 1'b0, 1'b1, a, d, 1'b0, 16'h0, 16'h0);
   endtask

   task automatic cpuRead(input logic [15:0] a);
      applyStimulus(1'b0, 1'b1, 1'b0, a, 16'h0, 1'b0, 16'h0, 16'h0);
   endtask

   task automatic preload(input logic [15:0] a, input logic [15:0] d);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, a, d);
   endtask

   initial begin
      n_compared   = 0;
      n_mismatched = 0;
      cyc          = 0;
      Reset            = 1'b1;
      bus.OE           = 1'b0;
      bus.WE           = 1'b0;
      bus.ADDR         = 16'h0;
      bus.Data_to_SRAM = 16'h0;
      bus.Load_Valid   = 1'b0;
      bus.Load_Addr    = 16'h0;
      bus.Load_Data    = 16'h0;
      @(posedge Clk);
      modelReset();
      #1;
      checkOutput();
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);

      // Clear sweep: Init_Done must rise exactly after DEPTH edges; CPU strobes are ignored meanwhile.
      cpuWrite(16'h0003, 16'hDEAD);
      idle(DEPTH - 1);
      cpuRead(16'h0123);
      cpuRead(16'h0003);
      idle(3);

      // Write then read the same address on the very next edge.
      cpuWrite(16'h0005, 16'hBEEF);
      cpuRead(16'h0005);
      idle(3);

      // Preloaded words read back-to-back return in order.
      preload(16'h0001, 16'h1111);
      preload(16'h0002, 16'h2222);
      preload(16'h0003, 16'h3333);
      cpuRead(16'h0001);
      cpuRead(16'h0002);
      cpuRead(16'h0003);
      idle(3);

      // Loader stalls while the CPU reads, then lands once OE drops.
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b0, 1'b1, 1'b0, 16'h0007, 16'h0, 1'b1, 16'h0010, 16'h1234);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0010, 16'h1234);
      cpuRead(16'h0010);
      idle(3);

      // Out-of-range accesses and the write-wins OE+WE case.
      cpuWrite(16'h8000, 16'hAAAA);
      cpuRead(16'h8000);
      cpuRead(16'h0000);
      applyStimulus(1'b0, 1'b1, 1'b1, 16'h0009, 16'h5555, 1'b0, 16'h0, 16'h0);
      preload(16'h8400, 16'h7777);
      cpuRead(16'h0009);
      cpuRead(16'h0000);
      idle(3);

      // Reset right behind a read kills the result and re-zeroes the array.
      cpuRead(16'h0005);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0020, 16'h4321);
      idle(DEPTH);
      cpuRead(16'h0005);
      cpuRead(16'h0020);
      idle(3);

      // Random traffic on a small address window so reads hit recent writes.
      for (int i = 0; i < 600; i++) begin
         logic [15:0] a;
         logic [15:0] la;
         a  = ($urandom_range(0, 7) == 0) ? (16'h8000 | 16'($urandom_range(0, 15))) : 16'($urandom_range(0, 15));
         la = ($urandom_range(0, 7) == 0) ? (16'h0400 | 16'($urandom_range(0, 15))) : 16'($urandom_range(0, 15));
         applyStimulus(1'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                       a, 16'($urandom), 1'($urandom_range(0, 1)), la, 16'($urandom));
      end
      idle(READ_LAT + 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end
endmodule
